// File: rtl/seg_scan_entry_ctrl.sv
// seg_scan_entry_ctrl
// Keypad entry buffer and display scanner that feeds an 8-digit
// seven-segment decoder. Keypad strobes shift codes into the buffer from the
// right, backspace or clear it. A prescaler steps a scan index, and the
// enabled digit's code and decimal point are registered onto the outputs.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   key_valid  strobe: key_code is valid (0-9 digit, 10 '-', 11 'u')
//   key_code   entry code; 12..15 are ignored
//   key_back   strobe: delete the most recently entered digit
//   key_clr    strobe: clear all digits
//   dp_mask    decimal point per position, sampled live
//   light_on   one-hot digit enable, bit 0 = rightmost
//   BCD        code of the enabled digit, 4'hF = blank
//   DP         decimal point of the enabled digit
//   digit_cnt  number of entered digits, 0..8
//   full       digit_cnt == 8 (combinational)
//   overflow   one-cycle pulse: entry rejected because the buffer is full
module seg_scan_entry_ctrl #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_back,
  input  logic       key_clr,
  input  logic [7:0] dp_mask,
  output logic [7:0] light_on,
  output logic [3:0] BCD,
  output logic       DP,
  output logic [3:0] digit_cnt,
  output logic       full,
  output logic       overflow
);

  localparam int unsigned NDIG = 8;
  localparam int unsigned PW   = $clog2(CLK_DIV);
  localparam logic [3:0]  BLANK    = 4'hF;
  localparam logic [3:0]  MAX_CODE = 4'd11;
  localparam logic [3:0]  MAX_CNT  = 4'd8;

  logic [3:0]    pos_q [NDIG];
  logic [3:0]    pos_d [NDIG];
  logic [3:0]    cnt_d;
  logic          ovf_d;
  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic          code_ok_c;
  logic          presc_tc_c;

  assign code_ok_c  = (key_code <= MAX_CODE);
  assign presc_tc_c = (presc_q == PW'(CLK_DIV - 1));
  assign full       = (digit_cnt == MAX_CNT);

  // Buffer command decode: clear beats backspace beats entry.
  always_comb begin
    for (int unsigned i = 0; i < NDIG; i++) pos_d[i] = pos_q[i];
    cnt_d = digit_cnt;
    ovf_d = 1'b0;
    if (key_clr) begin
      for (int unsigned i = 0; i < NDIG; i++) pos_d[i] = BLANK;
      cnt_d = 4'd0;
    end else if (key_back) begin
      if (digit_cnt != 4'd0) begin
        for (int unsigned i = 0; i < NDIG - 1; i++) pos_d[i] = pos_q[i+1];
        pos_d[NDIG-1] = BLANK;
        cnt_d = digit_cnt - 4'd1;
      end
    end else if (key_valid && code_ok_c) begin
      if (digit_cnt < MAX_CNT) begin
        for (int unsigned i = 1; i < NDIG; i++) pos_d[i] = pos_q[i-1];
        pos_d[0] = key_code;
        cnt_d = digit_cnt + 4'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Buffer, count and overflow pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NDIG; i++) pos_q[i] <= BLANK;
      digit_cnt <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NDIG; i++) pos_q[i] <= pos_d[i];
      digit_cnt <= cnt_d;
      overflow  <= ovf_d;
    end
  end

  // Prescaler and scan index; index wraps 7 -> 0 naturally in 3 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
    end else if (presc_tc_c) begin
      presc_q <= '0;
      idx_q   <= idx_q + 3'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Display output register, refreshed every cycle from the current index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      light_on <= 8'h00;
      BCD      <= BLANK;
      DP       <= 1'b0;
    end else begin
      light_on <= 8'h01 << idx_q;
      BCD      <= pos_q[idx_q];
      DP       <= dp_mask[idx_q];
    end
  end

endmodule

// File: tb/tb_seg_scan_entry_ctrl.sv
// Self-checking bench for seg_scan_entry_ctrl with CLK_DIV = 4.
// Reference: entered digits kept in a queue (newest first), scan position
// derived from the count of cycles since reset release.
module tb_seg_scan_entry_ctrl;

  localparam int unsigned CLK_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_back;
  logic       key_clr;
  logic [7:0] dp_mask;
  logic [7:0] light_on;
  logic [3:0] BCD;
  logic       DP;
  logic [3:0] digit_cnt;
  logic       full;
  logic       overflow;

  seg_scan_entry_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_back  (key_back),
    .key_clr   (key_clr),
    .dp_mask   (dp_mask),
    .light_on  (light_on),
    .BCD       (BCD),
    .DP        (DP),
    .digit_cnt (digit_cnt),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [3:0] mq[$];
  int         since = 0;

  typedef struct {
    logic       clr;
    logic       back;
    logic       valid;
    logic [3:0] code;
    logic [3:0] ecnt;
    logic       eovf;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [3:0] mpos(input int i);
    if (i < mq.size()) return mq[i];
    return 4'hF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the reference, compare all outputs.
  task automatic step(input logic r, input logic c, input logic b, input logic v,
                      input logic [3:0] k, input logic [7:0] d);
    logic [7:0] e_light;
    logic [3:0] e_bcd;
    logic       e_dp;
    logic       e_ovf;
    int         idx;
    @(negedge clk);
    rst_n = r; key_clr = c; key_back = b; key_valid = v; key_code = k; dp_mask = d;
    e_ovf = 1'b0;
    if (!r) begin
      e_light = 8'h00; e_bcd = 4'hF; e_dp = 1'b0;
      mq.delete();
      since = 0;
    end else begin
      idx     = (since / CLK_DIV) % 8;
      e_light = 8'h01 << idx;
      e_bcd   = mpos(idx);
      e_dp    = d[idx];
      since++;
      if (c) mq.delete();
      else if (b) begin
        if (mq.size() > 0) void'(mq.pop_front());
      end else if (v && k <= 4'd11) begin
        if (mq.size() < 8) mq.push_front(k);
        else e_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("light_on", 32'(light_on), 32'(e_light));
    chk("bcd", 32'(BCD), 32'(e_bcd));
    chk("dp", 32'(DP), 32'(e_dp));
    chk("digit_cnt", 32'(digit_cnt), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == 8));
    chk("overflow", 32'(overflow), 32'(e_ovf));
  endtask

  task automatic idle(input logic [7:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, d);
  endtask

  task automatic enter(input logic [3:0] k);
    step(1'b1, 1'b0, 1'b0, 1'b1, k, 8'h00);
  endtask

  // Idle until position p is enabled (bounded), then check its code and DP.
  task automatic expect_scan(input int p, input logic [3:0] e_bcd, input logic e_dp,
                             input logic [7:0] d);
    logic [7:0] want;
    bit         hit;
    want = 8'h01 << p;
    hit  = 1'b0;
    for (int t = 0; t < 40; t++) begin
      idle(d);
      if (light_on == want) begin
        hit = 1'b1;
        break;
      end
    end
    chk("scan_reach", 32'(hit), 32'd1);
    chk("scan_bcd", 32'(BCD), 32'(e_bcd));
    chk("scan_dp", 32'(DP), 32'(e_dp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic       r, c, b, v;
    logic [3:0] k;
    logic [7:0] d;
    bit         hit;

    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; key_back = 1'b0;
    key_clr = 1'b0; dp_mask = 8'h00;

    // Directed vectors continuing from buffer "123": {clr, back, valid, code, cnt, ovf}
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd2, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'd5,  4'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'd7,  4'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'd1,  4'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'd2,  4'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'd4,  4'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 4'd13, 4'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4'd11, 4'd2, 1'b0};

    // Reset scan
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("rst_light", 32'(light_on), 32'h00);
    chk("rst_bcd", 32'(BCD), 32'hF);
    idle(8'h00);
    chk("first_edge_light", 32'(light_on), 32'h01);
    for (int i = 1; i <= 33; i++) begin
      idle(8'h00);
      if (i == 4)  chk("scan_adv_02", 32'(light_on), 32'h02);
      if (i == 28) chk("scan_adv_80", 32'(light_on), 32'h80);
      if (i == 32) chk("scan_wrap_01", 32'(light_on), 32'h01);
    end

    // Entry of 1,2,3 and its display
    enter(4'd1); enter(4'd2); enter(4'd3);
    chk("cnt_123", 32'(digit_cnt), 32'd3);
    expect_scan(0, 4'd3, 1'b0, 8'h00);
    expect_scan(1, 4'd2, 1'b0, 8'h00);
    expect_scan(2, 4'd1, 1'b0, 8'h00);
    expect_scan(3, 4'hF, 1'b0, 8'h00);
    expect_scan(7, 4'hF, 1'b0, 8'h00);

    // Table-driven backspace / clear / priority / illegal code
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].clr, tbl[i].back, tbl[i].valid, tbl[i].code, 8'h00);
      chk($sformatf("tbl%0d_cnt", i), 32'(digit_cnt), 32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].eovf));
    end
    expect_scan(0, 4'd11, 1'b0, 8'h00);
    expect_scan(1, 4'd1, 1'b0, 8'h00);

    // DP follows the enabled position
    expect_scan(2, 4'hF, 1'b1, 8'h04);
    expect_scan(3, 4'hF, 1'b0, 8'h04);

    // Overflow: nine entries into an empty buffer
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 1; i <= 8; i++) enter(4'(i));
    chk("ovf_cnt8", 32'(digit_cnt), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_quiet", 32'(overflow), 32'd0);
    enter(4'd9);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    idle(8'h00);
    chk("ovf_once", 32'(overflow), 32'd0);
    chk("ovf_cnt_hold", 32'(digit_cnt), 32'd8);
    for (int i = 0; i < 8; i++) expect_scan(i, 4'(8 - i), 1'b0, 8'h00);

    // Reset mid-frame at scan position 5
    hit = 1'b0;
    for (int t = 0; t < 40; t++) begin
      idle(8'hFF);
      if (light_on == 8'h20) begin
        hit = 1'b1;
        break;
      end
    end
    chk("mid_reach5", 32'(hit), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 8'hFF);
    chk("mid_rst_light", 32'(light_on), 32'h00);
    chk("mid_rst_dp", 32'(DP), 32'd0);
    chk("mid_rst_cnt", 32'(digit_cnt), 32'd0);
    expect_scan(0, 4'hF, 1'b0, 8'h00);
    expect_scan(5, 4'hF, 1'b0, 8'h00);

    // Randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 199) != 0);
      c = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 1) == 1);
      k = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      step(r, c, b, v, k, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
